button_event_scheduler: RTL
===========================

Name: button_event_scheduler

Overview:
Multi-button front end for the debounced-button/LED design. It debounces N raw buttons against a shared sample tick. Resulting press/release events are queued as per-button pending flags and a round-robin scheduler drains them one at a time over a valid/ready interface. An 8-bit LED port shows the running count of accepted press events.

Parameters:
N_BTN, 4, number of buttons (>=1); IDW = max(1, $clog2(N_BTN))
TICK_DIV, 50000, clk cycles per sample tick (>=1; 1 = tick every cycle)
DEBOUNCE_TICKS, 20, consecutive differing ticks needed to flip the stable level (>=1)
REPEAT_TICKS, 50, auto-repeat period in ticks (used only with HOLD_REPEAT_EN)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-high
button  in  N_BTN  raw asynchronous button levels, 1 = pressed
stable  out  N_BTN  debounced button levels
evt_valid  out  1  event presented
evt_ready  in  1  consumer accepts when evt_valid & evt_ready
evt_id  out  IDW  button index of presented event
evt_press  out  1  1 = press, 0 = release
ovr  out  1  sticky: a pending event was overwritten before dispatch
LED  out  8  count of accepted press events, wraps 255->0

Behaviour:
- Reset is asynchronous: all flops clear immediately. stable=0, evt_valid=0, evt_id=0, evt_press=0, ovr=0, LED=0, rr_ptr=0, all pending flags and counters 0. Release is synchronous to clk.
- Sync: 2-flop synchronizer per button. Raw-to-sync latency is 2 cycles.
- Prescaler: counts 0..TICK_DIV-1 and pulses tick in the cycle where count==TICK_DIV-1.
- Per-button debounce (tick cycles only):
  - sync[i]==stable[i]: cnt[i]<=0.
  - sync[i]!=stable[i] and cnt[i]<DEBOUNCE_TICKS-1: cnt[i]++.
  - sync[i]!=stable[i] and cnt[i]==DEBOUNCE_TICKS-1: stable[i] toggles, cnt[i]<=0, pend[i]<=1, ptype[i]<=new level.
  - A glitch shorter than DEBOUNCE_TICKS ticks produces no event.
- Overwrite: a new event on button i while pend[i]=1 replaces ptype[i] and sets ovr=1. ovr stays set until reset.
- Scheduler FSM, two states:
  - IDLE: evt_valid=0. If any pend bit is set, grant g = first set index searching from rr_ptr upward with wrap. Register evt_id=g and evt_press=ptype[g], clear pend[g], set rr_ptr<=(g+1) mod N_BTN, go to PRESENT.
  - PRESENT: evt_valid=1. evt_id and evt_press are held stable while evt_ready=0. On evt_ready=1, the event is accepted and the FSM returns to IDLE.
  - Throughput is at most one event per 2 cycles.
  - Latency: the stable flip and pend set happen on the same edge; evt_valid rises one cycle later if the FSM is in IDLE.
- Simultaneous grant and new event on the same button in the same cycle: the new event wins, pend[g] stays 1 with the new ptype, and ovr is not set.
- LED: increments by 1 on each accepted event with evt_press=1. Release events do not count.
- N_BTN=1: rr_ptr stays 0, evt_id=0.

Optional Feature:
HOLD_REPEAT_EN
- Defined: per-button repeat counter. While stable[i]=1 it counts ticks since the press flip. Every REPEAT_TICKS ticks it raises pend[i] with ptype=1; the same overwrite rules apply. The counter clears on release or reset.
- Undefined: no repeat logic; exactly one press event per debounced press.

Decomposition:
- Shared package: scheduler state enum (IDLE, PRESENT) and the IDW width function.
- One sub-module, btn_debounce_cell: synchronizer, cnt, stable, and the edge pulse with its level. It is instantiated N_BTN times in a generate loop.
- Prescaler, pending array, round-robin arbiter and LED counter live in the top.

Test Plan:
All scenarios use N_BTN=4, TICK_DIV=2, DEBOUNCE_TICKS=3 unless noted.
1. Glitch rejection: button[0] high 3 cycles then low -> stable=0, evt_valid never rises, LED=0.
2. Clean press: button[0] held high 20 cycles, evt_ready=1 -> stable[0]=1 within 2+6 cycles; one event id=0, press=1; LED=1.
3. Fairness: buttons 1,2,3 pressed in the same cycle, evt_ready=1, rr_ptr=0 -> events id 1,2,3 in order, spaced 2 cycles apart; LED=3.
4. Backpressure/overrun: press button 2, hold evt_ready=0 for 40 cycles. Meanwhile press and then release button 3 -> id=2/press=1 held stable throughout; ovr=1; after ready, next event is id=3 with press=0.
5. Reset mid-PRESENT: assert rst asynchronously while evt_valid=1 -> evt_valid, LED, stable and ovr all 0 before the next clk edge; no event after release with buttons low.
6. Macro: with HOLD_REPEAT_EN and REPEAT_TICKS=4, hold button 0 for 30 ticks -> press events at the flip and every 4 ticks after it (7 total). Without the macro -> exactly 1 event.

Source files
------------

// File: rtl/button_event_scheduler_pkg.sv
// Shared types for the button event scheduler: scheduler state and id width helper.
package button_event_scheduler_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } sched_state_t;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button lane: 2-flop synchronizer, tick-based debounce counter and stable level.
// evt pulses (combinationally) in the tick cycle where stable flips; level is the new value.
module btn_debounce_cell
  import button_event_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic button,
  output logic stable,
  output logic evt,
  output logic level
);

  localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_TICKS - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip  = tick && (s2 != stable) && (cnt == CMAX);
  assign evt   = flip;
  assign level = ~stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= button;
      s2 <= s1;
      if (tick) begin
        if (s2 == stable) begin
          cnt <= '0;
        end else if (flip) begin
          stable <= ~stable;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Debounced multi-button front end with pending flags, round-robin dispatch and press counter.
// Optional macro HOLD_REPEAT_EN adds auto-repeat press events while a button stays held.
module button_event_scheduler
  import button_event_scheduler_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_TICKS   = 50,
  localparam int IDW           = idw(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] stable,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic             evt_press,
  output logic             ovr,
  output logic [7:0]       LED
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]    pcnt;
  logic             tick;
  logic [N_BTN-1:0] dev, dlev, nev, nlev;
  logic [N_BTN-1:0] pend, ptype, gmask;
  logic [IDW-1:0]   rr_ptr, gnt;
  logic             gnt_fire, found;
  int unsigned      idx;
  sched_state_t     state, state_n;

  assign tick = (pcnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_cell #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_cell (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .button (button[i]),
      .stable (stable[i]),
      .evt    (dev[i]),
      .level  (dlev[i])
    );
  end

`ifdef HOLD_REPEAT_EN
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  logic [N_BTN-1:0] rep;

  // A debounced flip outranks a repeat in the same tick, so a release is never masked.
  for (genvar i = 0; i < N_BTN; i++) begin : g_rep
    logic [RW-1:0] rcnt;
    assign rep[i] = tick && stable[i] && !dev[i] && (rcnt == RW'(REPEAT_TICKS - 1));
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                     rcnt <= '0;
      else if (!stable[i] || dev[i]) rcnt <= '0;
      else if (tick)               rcnt <= rep[i] ? '0 : rcnt + 1'b1;
    end
  end

  assign nev  = dev | rep;
  assign nlev = dlev | ~dev;
`else
  assign nev  = dev;
  assign nlev = dlev;
`endif

  always_comb begin
    state_n  = state;
    gnt_fire = 1'b0;
    gnt      = '0;
    found    = 1'b0;
    idx      = 0;
    gmask    = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      idx = (k + 32'(rr_ptr)) % N_BTN;
      if (!found && pend[IDW'(idx)]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
    case (state)
      IDLE: begin
        if (found) begin
          state_n  = PRESENT;
          gnt_fire = 1'b1;
          gmask    = N_BTN'(1) << gnt;
        end
      end
      PRESENT: if (evt_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  assign evt_valid = (state == PRESENT);

  // New events are OR'ed in after the grant clear, so a same-cycle event re-arms the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      ptype     <= '0;
      rr_ptr    <= '0;
      evt_id    <= '0;
      evt_press <= 1'b0;
      ovr       <= 1'b0;
      LED       <= '0;
    end else begin
      if (gnt_fire) begin
        evt_id    <= gnt;
        evt_press <= ptype[gnt];
        rr_ptr    <= IDW'((32'(gnt) + 1) % N_BTN);
      end
      pend  <= (pend & ~gmask) | nev;
      ptype <= (ptype & ~nev) | (nlev & nev);
      if (|(nev & pend & ~gmask)) ovr <= 1'b1;
      if (evt_valid && evt_ready && evt_press) LED <= LED + 1'b1;
    end
  end

endmodule
